demux41_scan: RTL and testbench

- Receiving end of the 4:1 keyed-select path.
- Drives the select key to an upstream 4:1 selector and samples the selected data each cycle.
- Rebuilds the full NR_KEY-slot input vector and presents it as a frame on a valid/ready output.
- Sits between any keyed selector and a consumer that needs the whole vector at once.

---
 rtl/demux41_scan_pkg.sv | 13 +
 rtl/demux41_scan_key.sv | 23 ++
 rtl/demux41_scan.sv | 120 ++++++++++++
 tb/tb_demux41_scan.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux41_scan_pkg.sv
// Shared definitions for the keyed-select receive path: FSM encoding and default sizes.
package demux41_scan_pkg;

    localparam int unsigned DEF_NR_KEY   = 4;
    localparam int unsigned DEF_KEY_LEN  = 2;
    localparam int unsigned DEF_DATA_LEN = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/demux41_scan_key.sv
// Keyed decoder: turns a select key into a one-hot write-enable vector.
module demux41_scan_key #(
    parameter int unsigned NR_KEY  = 4,
    parameter int unsigned KEY_LEN = 2
) (
    input  logic [KEY_LEN-1:0] key,
    input  logic               en,
    output logic [NR_KEY-1:0]  we_c
);

    // Keys at or above NR_KEY match no slot and decode to all-zero.
    always_comb begin
        we_c = '0;
        if (en) begin
            for (int unsigned k = 0; k < NR_KEY; k++) begin
                if (key == KEY_LEN'(k)) begin
                    we_c[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux41_scan.sv
// Scans an upstream keyed selector slot by slot and hands the rebuilt vector
// to a consumer as one frame over valid/ready.
module demux41_scan
    import demux41_scan_pkg::*;
#(
    parameter int unsigned NR_KEY   = DEF_NR_KEY,
    parameter int unsigned KEY_LEN  = DEF_KEY_LEN,
    parameter int unsigned DATA_LEN = DEF_DATA_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic [KEY_LEN-1:0]           sel_o,
    input  logic [DATA_LEN-1:0]          y_i,
    output logic [NR_KEY*DATA_LEN-1:0]   frame_o,
    output logic                         frame_valid_o,
    input  logic                         frame_ready_i,
    output logic                         overrun_o
);

    localparam int unsigned FRAME_W = NR_KEY * DATA_LEN;

    state_t               state, state_nxt;
    logic [KEY_LEN-1:0]   sel_nxt;
    logic [FRAME_W-1:0]   shadow, shadow_nxt;
    logic [FRAME_W-1:0]   frame_nxt;
    logic                 valid_nxt;
    logic                 overrun_nxt;
    logic [NR_KEY-1:0]    we_c;
    logic                 scan_c;
    logic                 last_c;
    logic                 slot_free_c;
    logic                 complete_c;

    assign scan_c = (state == ST_SCAN) && en;

    demux41_scan_key #(
        .NR_KEY  (NR_KEY),
        .KEY_LEN (KEY_LEN)
    ) u_key (
        .key  (sel_o),
        .en   (scan_c),
        .we_c (we_c)
    );

    // Next-state, shadow capture and output handshake.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_o;
        shadow_nxt  = shadow;
        frame_nxt   = frame_o;
        valid_nxt   = frame_valid_o;
        overrun_nxt = overrun_o;

        last_c      = (sel_o == KEY_LEN'(NR_KEY - 1));
        slot_free_c = !frame_valid_o || frame_ready_i;
        complete_c  = scan_c && last_c;

        for (int unsigned k = 0; k < NR_KEY; k++) begin
            if (we_c[k]) begin
                shadow_nxt[k*DATA_LEN +: DATA_LEN] = y_i;
            end
        end

        case (state)
            ST_IDLE: begin
                sel_nxt = '0;
                if (en) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = '0;
                end else if (last_c) begin
                    sel_nxt = '0;
                end else begin
                    sel_nxt = sel_o + KEY_LEN'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                sel_nxt   = '0;
            end
        endcase

        // Candidate frame already carries the current y_i in the last slot.
        if (frame_valid_o && frame_ready_i) begin
            valid_nxt = 1'b0;
        end
        if (complete_c) begin
            if (slot_free_c) begin
                frame_nxt = shadow_nxt;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sel_o         <= '0;
            shadow        <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            sel_o         <= sel_nxt;
            shadow        <= shadow_nxt;
            frame_o       <= frame_nxt;
            frame_valid_o <= valid_nxt;
            overrun_o     <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_demux41_scan.sv
// Directed bench for demux41_scan: a 4-slot instance plus a 3-slot instance,
// each fed by a behavioural model of the upstream selector.
module tb_demux41_scan;

    logic       clk;
    logic       rst_n;

    logic       en4, rdy4;
    logic [3:0] a4;
    logic [1:0] sel4;
    logic       y4;
    logic [3:0] frame4;
    logic       valid4, ovr4;

    logic       en3, rdy3;
    logic [2:0] a3;
    logic [3:0] a3_ext;
    logic [1:0] sel3;
    logic       y3;
    logic [2:0] frame3;
    logic       valid3, ovr3;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream selectors: y = a[sel]
    assign y4     = a4[sel4];
    assign a3_ext = {1'b0, a3};
    assign y3     = a3_ext[sel3];

    demux41_scan dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en4),
        .sel_o         (sel4),
        .y_i           (y4),
        .frame_o       (frame4),
        .frame_valid_o (valid4),
        .frame_ready_i (rdy4),
        .overrun_o     (ovr4)
    );

    demux41_scan #(
        .NR_KEY   (3),
        .KEY_LEN  (2),
        .DATA_LEN (1)
    ) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en3),
        .sel_o         (sel3),
        .y_i           (y3),
        .frame_o       (frame3),
        .frame_valid_o (valid3),
        .frame_ready_i (rdy3),
        .overrun_o     (ovr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [1:0] s, input logic v,
                        input logic [3:0] f, input logic o);
        chk({tag, ".sel"},     32'(sel4),   32'(s));
        chk({tag, ".valid"},   32'(valid4), 32'(v));
        chk({tag, ".frame"},   32'(frame4), 32'(f));
        chk({tag, ".overrun"}, 32'(ovr4),   32'(o));
    endtask

    initial begin
        rst_n = 1'b1;
        en4 = 1'b0; rdy4 = 1'b0; a4 = 4'b0000;
        en3 = 1'b0; rdy3 = 1'b0; a3 = 3'b000;
        #1 rst_n = 1'b0;
        #2;
        chk4("reset0", 2'd0, 1'b0, 4'b0000, 1'b0);
        #19 rst_n = 1'b1;

        // Idle with en low
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.sel",   32'(sel4),   32'd0);
            chk("idle.valid", 32'(valid4), 32'd0);
        end

        // Basic frame a=1011
        en4 = 1'b1; a4 = 4'b1011; rdy4 = 1'b1;
        step();
        chk4("basic.k", 2'd0, 1'b0, 4'b0000, 1'b0);
        step(); chk4("basic.k1", 2'd1, 1'b0, 4'b0000, 1'b0);
        step(); chk4("basic.k2", 2'd2, 1'b0, 4'b0000, 1'b0);
        step(); chk4("basic.k3", 2'd3, 1'b0, 4'b0000, 1'b0);
        step(); chk4("basic.k4", 2'd0, 1'b1, 4'b1011, 1'b0);

        // Back-to-back frames 0110 then 1001
        a4 = 4'b0110;
        step(); chk4("b2b.k5", 2'd1, 1'b0, 4'b1011, 1'b0);
        step(); chk4("b2b.k6", 2'd2, 1'b0, 4'b1011, 1'b0);
        step(); chk4("b2b.k7", 2'd3, 1'b0, 4'b1011, 1'b0);
        step(); chk4("b2b.k8", 2'd0, 1'b1, 4'b0110, 1'b0);
        a4 = 4'b1001;
        step(); chk4("b2b.k9", 2'd1, 1'b0, 4'b0110, 1'b0);
        step(); step();
        chk4("b2b.k11", 2'd3, 1'b0, 4'b0110, 1'b0);
        step(); chk4("b2b.k12", 2'd0, 1'b1, 4'b1001, 1'b0);

        // Backpressure: frame 0101 held while 1111 frames are dropped
        a4 = 4'b0101;
        step(); step(); step(); step();
        chk4("bp.k16", 2'd0, 1'b1, 4'b0101, 1'b0);
        rdy4 = 1'b0; a4 = 4'b1111;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("bp.hold.valid", 32'(valid4), 32'd1);
            chk("bp.hold.frame", 32'(frame4), 32'h5);
            chk("bp.hold.ovr",   32'(ovr4),   (i >= 4) ? 32'd1 : 32'd0);
        end
        rdy4 = 1'b1;
        step(); chk4("bp.k26", 2'd2, 1'b0, 4'b0101, 1'b1);
        step(); step();
        chk4("bp.k28", 2'd0, 1'b1, 4'b1111, 1'b1);

        // Async reset mid-cycle, no edge needed
        step();
        chk("pre_rst.sel", 32'(sel4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk4("rst_mid", 2'd0, 1'b0, 4'b0000, 1'b0);
        en4 = 1'b0; rdy4 = 1'b0;
        #1 rst_n = 1'b1;

        // Accept and completion on the same edge
        en4 = 1'b1; a4 = 4'b1100;
        step();
        chk4("sim.j", 2'd0, 1'b0, 4'b0000, 1'b0);
        step(); step(); step(); step();
        chk4("sim.j4", 2'd0, 1'b1, 4'b1100, 1'b0);
        a4 = 4'b0011;
        step(); step(); step();
        chk4("sim.j7", 2'd3, 1'b1, 4'b1100, 1'b0);
        rdy4 = 1'b1;
        step();
        chk4("sim.j8", 2'd0, 1'b1, 4'b0011, 1'b0);

        // Abort after two slots, then restart
        a4 = 4'b1010;
        step(); step();
        chk4("abort.j10", 2'd2, 1'b0, 4'b0011, 1'b0);
        en4 = 1'b0;
        step(); chk4("abort.j11", 2'd0, 1'b0, 4'b0011, 1'b0);
        step(); chk4("abort.j12", 2'd0, 1'b0, 4'b0011, 1'b0);
        en4 = 1'b1; a4 = 4'b0111;
        step(); chk4("restart.j13", 2'd0, 1'b0, 4'b0011, 1'b0);
        step(); step(); step();
        chk4("restart.j16", 2'd3, 1'b0, 4'b0011, 1'b0);
        step();
        chk4("restart.j17", 2'd0, 1'b1, 4'b0111, 1'b0);
        en4 = 1'b0;

        // Three-slot instance: wrap at 2, 3-bit frames
        chk("n3.idle.sel",   32'(sel3),   32'd0);
        chk("n3.idle.valid", 32'(valid3), 32'd0);
        en3 = 1'b1; rdy3 = 1'b1; a3 = 3'b101;
        step(); chk("n3.m.sel",  32'(sel3), 32'd0);
        step(); chk("n3.m1.sel", 32'(sel3), 32'd1);
        step(); chk("n3.m2.sel", 32'(sel3), 32'd2);
        chk("n3.m2.valid", 32'(valid3), 32'd0);
        step();
        chk("n3.m3.sel",   32'(sel3),   32'd0);
        chk("n3.m3.valid", 32'(valid3), 32'd1);
        chk("n3.m3.frame", 32'(frame3), 32'h5);
        a3 = 3'b010;
        step(); chk("n3.m4.valid", 32'(valid3), 32'd0);
        step(); step();
        chk("n3.m6.valid", 32'(valid3), 32'd1);
        chk("n3.m6.frame", 32'(frame3), 32'h2);
        chk("n3.m6.ovr",   32'(ovr3),   32'd0);
        en3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
